// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and shared-memory signals of the arbitrated memory port
interface mem_port_arbiter_if;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_func3;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        if_stall;
  logic        d_stall;
  logic [7:0]  mem_addr;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_data_in;
  logic [2:0]  mem_func3;
  logic [31:0] mem_data_out;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3, mem_data_out,
    output if_valid, if_rdata, d_valid, d_rdata, if_stall, d_stall,
           mem_addr, mem_MemRead, mem_MemWrite, mem_data_in, mem_func3
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3, mem_data_out,
    input  if_valid, if_rdata, d_valid, d_rdata, if_stall, d_stall,
           mem_addr, mem_MemRead, mem_MemWrite, mem_data_in, mem_func3
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between instruction fetch and load/store with bounded fetch starvation
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);
  localparam logic [7:0] SMAX     = 8'(STARVE_MAX);
  state_t      r_state, w_next;
  logic        r_owner_if, r_we, r_if_valid, r_d_valid;
  logic [7:0]  r_addr, r_starve;
  logic [31:0] r_wdata, r_if_rdata, r_d_rdata;
  logic [2:0]  r_func3;
  logic [1:0]  r_lat;
  logic        w_any, w_grant_if, w_last;
  assign w_any      = bus.if_req | bus.d_req;
  assign w_grant_if = bus.if_req & (~bus.d_req | (r_starve == SMAX));
  assign w_last     = r_lat == LAT_LAST;
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // next state: one grant per IDLE, MEM_LAT cycles of ACCESS, one RESP cycle
  always_comb
    w_next = (r_state == IDLE)   ? (w_any ? ACCESS : IDLE) :
             (r_state == ACCESS) ? (w_last ? RESP : ACCESS) : IDLE;
  // latch the winning request, count latency, capture read data and raise valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_if <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_func3    <= '0;
      r_lat      <= '0;
      r_starve   <= '0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      if (r_state == IDLE) begin
        r_starve <= (~bus.if_req | w_grant_if) ? '0 :
                    (r_starve == SMAX) ? r_starve : r_starve + 8'd1;
        if (w_any) begin
          r_owner_if <= w_grant_if;
          r_addr     <= w_grant_if ? bus.if_addr : bus.d_addr;
          r_we       <= ~w_grant_if & bus.d_we;
          r_wdata    <= bus.d_wdata;
          r_func3    <= w_grant_if ? 3'b010 : bus.d_func3;
          r_lat      <= '0;
        end
      end else if (r_state == ACCESS) begin
        r_lat <= r_lat + 2'd1;
        if (w_last) begin
          r_if_valid <= r_owner_if;
          r_d_valid  <= ~r_owner_if;
          if (r_owner_if)
            r_if_rdata <= bus.mem_data_out;
          else if (~r_we)
            r_d_rdata <= bus.mem_data_out;
        end
      end
    end
  end
  // memory strobes only during ACCESS; all other memory fields come straight from latched state
  always_comb begin
    bus.mem_MemRead  = (r_state == ACCESS) & ~r_we;
    bus.mem_MemWrite = (r_state == ACCESS) & r_we;
    bus.mem_addr     = r_addr;
    bus.mem_data_in  = r_wdata;
    bus.mem_func3    = r_func3;
    bus.if_valid     = r_if_valid;
    bus.d_valid      = r_d_valid;
    bus.if_rdata     = r_if_rdata;
    bus.d_rdata      = r_d_rdata;
    bus.if_stall     = bus.if_req & ~r_if_valid;
    bus.d_stall      = bus.d_req & ~r_d_valid;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with memory model, directed cases and random fetch/data traffic
module tb_mem_port_arbiter;
  typedef struct {logic [31:0] data; int due;} exp_t;
  logic clk = 1'b0;
  logic rst, rst3;
  int tests = 0, fails = 0, cyc = 0;
  logic mon_en = 1'b0, chk_bus = 1'b0;
  exp_t qf[$], qd[$];
  logic [31:0] mem[256];
  logic [255:0] wr;
  logic [31:0] sh[256];
  logic [255:0] shw;
  logic [31:0] last_d;
  logic cur_we;
  logic [31:0] cur_wd;
  logic [2:0] cur_f3;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_port_arbiter_if a();
  mem_port_arbiter_if b();
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) dut (.clk(clk), .rst(rst), .bus(a.slave));
  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(3)) dut3 (.clk(clk), .rst(rst3), .bus(b.slave));
  function automatic logic [31:0] initv(input logic [7:0] ad);
    return ad == 8'h04 ? 32'h00A00093 : ad == 8'h40 ? 32'hDEADBEEF : {ad, ~ad, ad ^ 8'h5A, 8'hC3};
  endfunction
  function automatic logic [31:0] rd(input logic [7:0] ad);
    return shw[ad] ? sh[ad] : initv(ad);
  endfunction
  assign a.mem_data_out = wr[a.mem_addr] ? mem[a.mem_addr] : initv(a.mem_addr);
  assign b.mem_data_out = {24'hCAFE00, b.mem_addr};
  always @(posedge clk)
    if (rst) wr <= '0;
    else if (a.mem_MemWrite) begin
      mem[a.mem_addr] <= a.mem_data_in;
      wr[a.mem_addr]  <= 1'b1;
    end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
    end
  endtask
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  task automatic wait_if;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (a.if_valid) seen = 1'b1;
      else if (a.if_req) chk("if_stall_wait", a.if_stall, 1);
    end
    chk("if_timeout", seen, 1);
    #1;
  endtask
  task automatic wait_d;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (a.d_valid) seen = 1'b1;
      else if (a.d_req) chk("d_stall_wait", a.d_stall, 1);
    end
    chk("d_timeout", seen, 1);
    #1;
  endtask
  task automatic do_fetch(input logic [7:0] ad, input int due_off);
    exp_t e;
    a.if_addr = ad;
    a.if_req  = 1'b1;
    e.data = rd(ad);
    e.due  = due_off < 0 ? -1 : cyc + due_off;
    qf.push_back(e);
    wait_if();
    a.if_req = 1'b0;
  endtask
  task automatic data_issue(input logic we, input logic [7:0] ad, input logic [31:0] wd,
                            input logic [2:0] f3, input int due_off);
    exp_t e;
    a.d_we = we; a.d_addr = ad; a.d_wdata = wd; a.d_func3 = f3; a.d_req = 1'b1;
    cur_we = we; cur_wd = wd; cur_f3 = f3;
    if (we) begin
      sh[ad]  = wd;
      shw[ad] = 1'b1;
    end else last_d = rd(ad);
    e.data = last_d;
    e.due  = due_off < 0 ? -1 : cyc + due_off;
    qd.push_back(e);
  endtask
  task automatic do_data(input logic we, input logic [7:0] ad, input logic [31:0] wd,
                         input logic [2:0] f3, input int due_off);
    data_issue(we, ad, wd, f3, due_off);
    wait_d();
    a.d_req = 1'b0;
  endtask
  // scoreboard: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) if (mon_en) begin
    exp_t e;
    if (a.if_valid) begin
      if (qf.size() == 0) chk("if_valid_unexpected", 1, 0);
      else begin
        e = qf.pop_front();
        chk("if_rdata", a.if_rdata, e.data);
        if (e.due >= 0) chk("if_latency", cyc, e.due);
      end
    end
    if (a.d_valid) begin
      if (qd.size() == 0) chk("d_valid_unexpected", 1, 0);
      else begin
        e = qd.pop_front();
        chk("d_rdata", a.d_rdata, e.data);
        if (e.due >= 0) chk("d_latency", cyc, e.due);
      end
    end
    if (!a.if_req) chk("if_stall_noreq", a.if_stall, 0);
    if (!a.d_req) chk("d_stall_noreq", a.d_stall, 0);
  end
  // memory-bus contents during random traffic: fetches live below 0x80, data at 0x80 and above
  always @(negedge clk) if (chk_bus && (a.mem_MemRead || a.mem_MemWrite)) begin
    if (!a.mem_addr[7]) begin
      chk("f_memread", a.mem_MemRead, 1);
      chk("f_memwrite", a.mem_MemWrite, 0);
      chk("f_func3", a.mem_func3, 3'b010);
    end else begin
      chk("d_memwrite", a.mem_MemWrite, cur_we);
      chk("d_memread", a.mem_MemRead, !cur_we);
      chk("d_func3", a.mem_func3, cur_f3);
      if (cur_we) chk("d_mem_data_in", a.mem_data_in, cur_wd);
    end
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int c0;
    logic [2:0] f3s[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    a.if_req = 0; a.if_addr = 0; a.d_req = 0; a.d_we = 0; a.d_addr = 0; a.d_wdata = 0; a.d_func3 = 0;
    b.if_req = 0; b.if_addr = 0; b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_wdata = 0; b.d_func3 = 0;
    rst = 1'b1; rst3 = 1'b1; shw = '0; last_d = '0;
    cur_we = 0; cur_wd = 0; cur_f3 = 0;
    repeat (3) @(negedge clk);
    chk("rst_a_zero", |{a.if_valid, a.d_valid, a.if_rdata, a.d_rdata, a.mem_addr,
                        a.mem_MemRead, a.mem_MemWrite, a.mem_data_in, a.mem_func3}, 0);
    chk("rst_b_zero", |{b.if_valid, b.d_valid, b.if_rdata, b.d_rdata, b.mem_addr,
                        b.mem_MemRead, b.mem_MemWrite, b.mem_data_in, b.mem_func3}, 0);
    chk("rst_stall", {a.if_stall, a.d_stall}, 0);
    #1 rst = 1'b0; rst3 = 1'b0; mon_en = 1'b1;
    // lone fetch
    step();
    fork
      do_fetch(8'h04, 2);
      begin
        @(negedge clk);
        chk("t1_memread", a.mem_MemRead, 1);
        chk("t1_addr", a.mem_addr, 8'h04);
        chk("t1_func3", a.mem_func3, 3'b010);
      end
    join
    // simultaneous fetch and load: data first, fetch three cycles later
    step();
    fork
      do_fetch(8'h04, 5);
      do_data(1'b0, 8'h40, 32'h0, 3'b010, 2);
    join
    // store: one write cycle, load result preserved, then read back
    step();
    fork
      do_data(1'b1, 8'h80, 32'h12345678, 3'b010, 2);
      begin
        int n = 0;
        repeat (3) begin
          @(negedge clk);
          n += int'(a.mem_MemWrite);
        end
        chk("store_write_cycles", n, 1);
      end
    join
    step();
    do_data(1'b0, 8'h80, 32'h0, 3'b010, 2);
    // request fields changing after grant must not affect the access in flight
    step();
    fork
      do_data(1'b1, 8'h90, 32'hAAAA5555, 3'b000, 2);
      begin
        @(negedge clk);
        #2;
        a.d_addr = 8'h91; a.d_wdata = 32'h0; a.d_we = 1'b0;
      end
    join
    step();
    do_data(1'b0, 8'h90, 32'h0, 3'b010, 2);
    step();
    do_data(1'b0, 8'h91, 32'h0, 3'b010, 2);
    // d_req dropped during ACCESS: valid still pulses, next request accepted
    step();
    data_issue(1'b0, 8'h40, 32'h0, 3'b010, 2);
    step();
    a.d_req = 1'b0;
    wait_d();
    step();
    do_data(1'b0, 8'h80, 32'h0, 3'b010, 2);
    // both requests held: grant order D,D,D,F,D,D,D,F
    step();
    c0 = cyc;
    a.if_addr = 8'h04; a.if_req = 1'b1;
    a.d_we = 1'b0; a.d_addr = 8'h40; a.d_func3 = 3'b010; a.d_req = 1'b1;
    last_d = rd(8'h40);
    foreach (f3s[i]) if (i < 3) qd.push_back('{last_d, c0 + 2 + 3 * i});
    qf.push_back('{rd(8'h04), c0 + 11});
    foreach (f3s[i]) if (i < 3) qd.push_back('{last_d, c0 + 14 + 3 * i});
    qf.push_back('{rd(8'h04), c0 + 23});
    for (int r = 1; r <= 23; r++) begin
      @(negedge clk);
      chk("starve_if_stall", a.if_stall, !(r == 11 || r == 23));
      chk("starve_d_stall", a.d_stall, !(r inside {2, 5, 8, 14, 17, 20}));
    end
    #1 a.if_req = 1'b0; a.d_req = 1'b0;
    // MEM_LAT=3 load latency, then reset in the second ACCESS cycle of a store
    step();
    b.d_we = 1'b0; b.d_addr = 8'h21; b.d_func3 = 3'b001; b.d_req = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      if (r == 1) chk("l3_func3", b.mem_func3, 3'b001);
      if (r < 4) chk("l3_memread", b.mem_MemRead, 1);
      chk("l3_d_valid", b.d_valid, r == 4);
    end
    chk("l3_d_rdata", b.d_rdata, 32'hCAFE0021);
    #1 b.d_req = 1'b0;
    step();
    b.d_we = 1'b1; b.d_addr = 8'h80; b.d_wdata = 32'h12345678; b.d_func3 = 3'b010; b.d_req = 1'b1;
    @(negedge clk);
    chk("abort_wr_c1", b.mem_MemWrite, 1);
    @(negedge clk);
    chk("abort_wr_c2", b.mem_MemWrite, 1);
    #1 rst3 = 1'b1;
    @(negedge clk);
    chk("abort_memwrite", b.mem_MemWrite, 0);
    chk("abort_all_zero", |{b.if_valid, b.d_valid, b.if_rdata, b.d_rdata, b.mem_addr,
                            b.mem_MemRead, b.mem_data_in, b.mem_func3}, 0);
    #1 rst3 = 1'b0; b.d_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_valid", b.d_valid, 0);
    end
    // random concurrent traffic
    step();
    chk_bus = 1'b1;
    fork
      repeat (60) begin
        repeat ($urandom_range(0, 3)) step();
        do_fetch(8'($urandom_range(0, 127)), -1);
      end
      repeat (60) begin
        repeat ($urandom_range(0, 3)) step();
        do_data(1'($urandom_range(0, 1)), 8'h80 | 8'($urandom_range(0, 15)), $urandom,
                f3s[$urandom_range(0, 4)], -1);
      end
    join
    chk_bus = 1'b0;
    repeat (5) step();
    chk("qf_drained", qf.size(), 0);
    chk("qd_drained", qd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
